// File: rtl/asram16_pkg.sv
// Shared types and constants for the 16-bit async-SRAM responder.
package asram16_pkg;

  localparam int DATA_W  = 16;
  localparam int BE_W    = 2;
  localparam int CNT_W   = 4;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE         = 2'd0,
    WRITE_ACTIVE = 2'd1,
    READ_WAIT    = 2'd2,
    READ_VALID   = 2'd3
  } state_t;

  // True when any address bit above the decoded word index is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
    return (addr >> addr_w) != 32'd0;
  endfunction

endpackage

// File: rtl/asram16_responder_if.sv
// Async-SRAM pin bundle plus the responder's status pulses.
interface asram16_responder_if;
  import asram16_pkg::*;

  logic [31:0]       sram_address_i;
  logic [DATA_W-1:0] sram_data_in_i;
  logic              sram_oe_n_i;
  logic              sram_cs_n_i;
  logic [BE_W-1:0]   sram_be_n_i;
  logic              sram_we_n_i;
  logic [DATA_W-1:0] sram_data_out_o;
  logic              sram_data_valid_o;
  logic              write_done_o;
  logic              range_err_o;
  logic              proto_err_o;

  modport master (
    output sram_address_i, sram_data_in_i, sram_oe_n_i, sram_cs_n_i,
           sram_be_n_i, sram_we_n_i,
    input  sram_data_out_o, sram_data_valid_o, write_done_o, range_err_o,
           proto_err_o
  );

  modport slave (
    input  sram_address_i, sram_data_in_i, sram_oe_n_i, sram_cs_n_i,
           sram_be_n_i, sram_we_n_i,
    output sram_data_out_o, sram_data_valid_o, write_done_o, range_err_o,
           proto_err_o
  );

endinterface

// File: rtl/asram16_mem_array.sv
// Byte-writable 2^ADDR_W x 16 storage; contents are deliberately not reset.
module asram16_mem_array
  import asram16_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Each enabled byte lane takes its slice of the write data.
  always_ff @(posedge clk) begin
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be[b]) begin
        mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/asram16_responder.sv
// Memory end of the async-SRAM bus: decodes pin cycles into array writes and
// latency-delayed reads, and flags range and protocol violations.
module asram16_responder
  import asram16_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  asram16_responder_if.slave bus
);

  // Counter starts at latency-1 so valid lands READ_LATENCY edges after the
  // edge that first sampled the address.
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              rerr_q, rerr_d;
  logic              perr_q, perr_d;

  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] rd_data;
  logic              cs, oe, we;
  logic              write_req;
  logic              addr_changed;
  logic              addr_oor;

  assign cs           = !bus.sram_cs_n_i;
  assign oe           = !bus.sram_oe_n_i;
  assign we           = !bus.sram_we_n_i;
  assign write_req    = cs && we;
  assign addr_changed = bus.sram_address_i != addr_q;
  assign addr_oor     = addr_out_of_range(addr_q, ADDR_W);

  asram16_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk     (clk_i),
    .wr_be   (mem_be),
    .wr_addr (addr_q[ADDR_W-1:0]),
    .wr_data (wdata_q),
    .rd_addr (addr_q[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // State and output registers; the array itself is outside reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
      perr_q  <= perr_d;
    end
  end

  // Next-state decode; a write request pre-empts any read in progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    data_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rerr_d  = 1'b0;
    perr_d  = cs && we && oe;
    mem_be  = '0;

    if (write_req) begin
      state_d = WRITE_ACTIVE;
      addr_d  = bus.sram_address_i;
      wdata_d = bus.sram_data_in_i;
      be_d    = bus.sram_be_n_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs && oe) begin
            state_d = READ_WAIT;
            addr_d  = bus.sram_address_i;
            cnt_d   = LAT_LOAD;
          end
        end
        WRITE_ACTIVE: begin
          if (!addr_oor) begin
            mem_be = ~be_q;
          end
          done_d  = 1'b1;
          rerr_d  = addr_oor;
          state_d = IDLE;
        end
        READ_WAIT: begin
          if (!cs || !oe) begin
            state_d = IDLE;
          end else if (addr_changed) begin
            addr_d = bus.sram_address_i;
            cnt_d  = LAT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = READ_VALID;
            valid_d = 1'b1;
            data_d  = addr_oor ? '0 : rd_data;
            rerr_d  = addr_oor;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        READ_VALID: begin
          if (!cs || !oe) begin
            state_d = IDLE;
          end else if (addr_changed) begin
            state_d = READ_WAIT;
            addr_d  = bus.sram_address_i;
            cnt_d   = LAT_LOAD;
          end else begin
            valid_d = 1'b1;
            data_d  = data_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (rst_i) begin
      mem_be = '0;
    end
  end

  assign bus.sram_data_out_o   = data_q;
  assign bus.sram_data_valid_o = valid_q;
  assign bus.write_done_o      = done_q;
  assign bus.range_err_o       = rerr_q;
  assign bus.proto_err_o       = perr_q;

endmodule

// File: doc/asram16_responder.md
Name: asram16_responder

Overview:
- Synchronous responder for the 16-bit asynchronous-SRAM pin interface, i.e. the memory end of that bus.
- Sits opposite the AXI4-to-async-SRAM bridge in simulation and FPGA loopback builds, in place of the external SRAM device.
- Decodes chip-select, output-enable, write-enable and byte-enable pins into byte-lane writes to an internal 2^ADDR_W x 16 array.
- Returns read data after a programmable access latency and flags protocol violations.

Parameters:
- ADDR_W, 8: word-address bits decoded; array depth is 2^ADDR_W 16-bit words.
- READ_LATENCY, 2: cycles from accepted read address to valid data. Legal range 1..15; must not exceed the controller's read wait count.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  reset, synchronous, active-high
- sram_address_i  input  32  16-bit-word address from controller
- sram_data_in_i  input  16  write data from controller
- sram_oe_n_i  input  1  output enable, active-low
- sram_cs_n_i  input  1  chip select, active-low
- sram_be_n_i  input  2  byte enables, active-low; bit0 = [7:0], bit1 = [15:8]
- sram_we_n_i  input  1  write enable, active-low
- sram_data_out_o  output  16  read data to controller
- sram_data_valid_o  output  1  read data valid for the current address
- write_done_o  output  1  one-cycle pulse on write commit
- range_err_o  output  1  one-cycle pulse on an access with sram_address_i >= 2^ADDR_W
- proto_err_o  output  1  one-cycle pulse when cs_n=0, we_n=0 and oe_n=0 are sampled together

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values: state IDLE; sram_data_out_o=16'h0000; all flag outputs 0; latency counter 0; pending-write latch cleared. Array contents are not reset and survive reset.
- Pins are sampled directly on each rising edge. There is no input synchroniser because the controller is on the same clock.

State machine (states live in the package):
- IDLE
  - cs_n=0 and we_n=0 -> WRITE_ACTIVE; latch address, data and be_n.
  - else cs_n=0, oe_n=0, we_n=1 -> READ_WAIT; latch address; counter = READ_LATENCY-1.
- WRITE_ACTIVE
  - Each cycle with we_n=0 and cs_n=0: relatch address, data and be_n (last value wins).
  - First cycle with we_n=1 or cs_n=1:
    - Commit: byte lanes with be_n=0 take the latched data; be_n=2'b11 writes nothing but still pulses.
    - Pulse write_done_o in that cycle (registered; visible next cycle).
    - Return to IDLE.
- READ_WAIT
  - Counter decrements each cycle.
  - At 0 -> READ_VALID; sram_data_out_o = array[addr], sram_data_valid_o=1.
  - Any change of sram_address_i while waiting restarts the latency count with the new address.
- READ_VALID
  - Data and valid held while cs_n=0, oe_n=0, address unchanged.
  - Address change with oe_n=0 -> READ_WAIT, valid=0 next cycle. This covers the controller's back-to-back increment from the low half to the high half.
  - oe_n=1 or cs_n=1 -> IDLE.
- Net latency: valid asserts exactly READ_LATENCY cycles after the edge that first samples the address.
- Whenever valid=0, sram_data_out_o is 16'h0000.
- we_n=0 in READ_WAIT or READ_VALID -> abandon the read and go to WRITE_ACTIVE (write has priority).

Boundary conditions:
- Out-of-range address:
  - write -> dropped, range_err_o pulses at commit, write_done_o still pulses;
  - read -> data 16'h0000 with valid=1 at normal latency, range_err_o pulses when valid rises.
- we_n, oe_n and cs_n all low: proto_err_o pulses each such cycle; treated as a write.
- cs_n=1: all other pins ignored.
- Reset mid-write: pending latch discarded, no commit, no write_done_o.
- Reset mid-read: valid drops the cycle after reset.
- Address index uses sram_address_i[ADDR_W-1:0]; the range check uses the full 32 bits.

Decomposition:
- asram16_pkg holds:
  - state encoding (IDLE=0, WRITE_ACTIVE=1, READ_WAIT=2, READ_VALID=3), 2-bit state width;
  - DATA_W=16 and BE_W=2;
  - the latency-counter width of 4.
- One sub-module, asram16_mem_array:
  - parameter ADDR_W;
  - single write port with 2-bit byte write enable;
  - combinational read port;
  - no reset.

Test Plan:
- Full-word write: addr 0x08, data 16'hBABE, be_n 2'b00, we_n low 8 cycles then high -> write_done_o one pulse; later read of 0x08 returns 16'hBABE with valid 2 cycles after address.
- Byte-lane write: preload 0x09=16'hCAFE; write 16'h1234 with be_n=2'b10 -> read 0x09 returns 16'hCA34.
- Back-to-back read: read 0x08, then address steps to 0x09 with oe_n held low -> valid drops one cycle, reasserts 2 cycles later with the 0x09 data.
- Out-of-range: ADDR_W=8, write 0x100 = 16'hFFFF -> range_err_o pulse, array[0x00] unchanged; read 0x100 -> 16'h0000 with valid.
- Protocol error and reset: we_n, oe_n, cs_n all 0 for 3 cycles -> proto_err_o high 3 cycles. rst_i asserted during WRITE_ACTIVE -> no commit, no write_done_o, outputs at reset values next cycle.
- Latency sweep READ_LATENCY=1 and 7 -> valid exactly 1 / 7 cycles after address sample; with 7, controller-side data sampled correctly.
